// File: rtl/led_pkg.sv
// Shared constants for the LED pattern controller: channel modes, config field
// widths and the zero-to-one parameter rule used by every channel.
package led_pkg;

  localparam int CFG_PARAM_W = 16;
  localparam int CFG_CH_W    = 8;

  localparam logic [1:0] LED_OFF     = 2'd0;
  localparam logic [1:0] LED_ON      = 2'd1;
  localparam logic [1:0] LED_BLINK   = 2'd2;
  localparam logic [1:0] LED_BREATHE = 2'd3;

  // A zero period would never produce a step event, so it behaves as one tick.
  function automatic logic [CFG_PARAM_W-1:0] effParam(input logic [CFG_PARAM_W-1:0] p);
    return (p == '0) ? CFG_PARAM_W'(1) : p;
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds its mode/param, divides the shared tick into step
// events and produces a registered blink or triangle-PWM drive.
module led_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   tick_i,
  input  logic [PWM_BITS-1:0]    pwmCnt_i,
  input  logic                   we_i,
  input  logic [1:0]             mode_i,
  input  logic [CFG_PARAM_W-1:0] param_i,
  output logic                   led_o
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [PWM_BITS-1:0] DUTY_ONE = PWM_BITS'(1);

  logic [1:0]             mode_q,  mode_d;
  logic [CFG_PARAM_W-1:0] param_q, param_d;
  logic [15:0]            tcnt_q,  tcnt_d;
  logic                   phase_q, phase_d;
  logic [PWM_BITS-1:0]    duty_q,  duty_d;
  logic                   dir_q,   dir_d;
  logic                   led_q,   led_d;
  logic                   step;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q  <= LED_OFF;
      param_q <= '0;
      tcnt_q  <= '0;
      phase_q <= 1'b0;
      duty_q  <= '0;
      dir_q   <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      param_q <= param_d;
      tcnt_q  <= tcnt_d;
      phase_q <= phase_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      led_q   <= led_d;
    end
  end

  // A write takes priority over a coincident tick, so a restart always begins cleanly.
  always_comb begin
    mode_d  = mode_q;
    param_d = param_q;
    tcnt_d  = tcnt_q;
    phase_d = phase_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    step    = 1'b0;

    if (we_i) begin
      mode_d  = mode_i;
      param_d = param_i;
      tcnt_d  = '0;
      phase_d = 1'b0;
      duty_d  = '0;
      dir_d   = 1'b0;
    end else if (mode_q == LED_OFF || mode_q == LED_ON) begin
      tcnt_d  = '0;
      phase_d = 1'b0;
      duty_d  = '0;
      dir_d   = 1'b0;
    end else if (tick_i) begin
      if (({1'b0, tcnt_q} + 17'd1) == {1'b0, effParam(param_q)}) begin
        tcnt_d = '0;
        step   = 1'b1;
      end else begin
        tcnt_d = tcnt_q + 16'd1;
      end
    end

    // The end points hold for one step while the direction turns around.
    if (step) begin
      if (mode_q == LED_BLINK) begin
        phase_d = ~phase_q;
      end else if (!dir_q) begin
        if (duty_q == DUTY_MAX) dir_d = 1'b1;
        else                    duty_d = duty_q + DUTY_ONE;
      end else begin
        if (duty_q == '0) dir_d = 1'b0;
        else              duty_d = duty_q - DUTY_ONE;
      end
    end
  end

  always_comb begin
    led_d = 1'b0;
    case (mode_q)
      LED_ON:      led_d = 1'b1;
      LED_BLINK:   led_d = phase_q;
      LED_BREATHE: led_d = (pwmCnt_i < duty_q);
      default:     led_d = 1'b0;
    endcase
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern controller: shared tick prescaler and PWM counter,
// config write decode, and one led_channel per LED.
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int NUM_LED     = 4,
  parameter int CLK_FREQ_HZ = 200_000_000,
  parameter int TICK_HZ     = 1000,
  parameter int PWM_BITS    = 8
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [CFG_CH_W-1:0]    cfg_ch,
  input  logic [1:0]             cfg_mode,
  input  logic [CFG_PARAM_W-1:0] cfg_param,
  output logic [NUM_LED-1:0]     led,
  output logic                   tick
);

  // CLK_FREQ_HZ must be an exact multiple of TICK_HZ with a quotient of at least 2.
  localparam int DIV     = CLK_FREQ_HZ / TICK_HZ;
  localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

  logic [PRESC_W-1:0]  presc_q,  presc_d;
  logic [PWM_BITS-1:0] pwmCnt_q, pwmCnt_d;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      pwmCnt_q <= '0;
    end else begin
      presc_q  <= presc_d;
      pwmCnt_q <= pwmCnt_d;
    end
  end

  always_comb begin
    presc_d  = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
    pwmCnt_d = pwmCnt_q + PWM_BITS'(1);
  end

  assign tick = (presc_q == PRESC_LAST);

  for (genvar i = 0; i < NUM_LED; i++) begin : g_ch
    logic chWe;
    assign chWe = cfg_we && (cfg_ch == CFG_CH_W'(i));

    led_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .clk_i    (sys_clk),
      .rst_i    (rst),
      .tick_i   (tick),
      .pwmCnt_i (pwmCnt_q),
      .we_i     (chWe),
      .mode_i   (cfg_mode),
      .param_i  (cfg_param),
      .led_o    (led[i])
    );
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with DIV=10 and 4-bit PWM; cyc counts
// clock edges since reset release so tick-aligned expectations are exact.
module tb_led_pattern_ctrl;
  import led_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_ch = '0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] cfg_param = '0;
  logic [3:0]  led;
  logic        tick;

  int assertCount = 0;
  int failCount = 0;
  int cyc = 0;

  led_pattern_ctrl #(
    .NUM_LED(4), .CLK_FREQ_HZ(1000), .TICK_HZ(100), .PWM_BITS(4)
  ) dut (
    .sys_clk(clock), .rst(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_param(cfg_param), .led(led), .tick(tick)
  );

  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Returns just after the capture edge; cfg_we is high for exactly that edge.
  task automatic applyStimulus(input int ch, input logic [1:0] mode, input logic [15:0] param);
    @(negedge clock);
    cfg_we = 1'b1;
    cfg_ch = 8'(ch);
    cfg_mode = mode;
    cfg_param = param;
    @(posedge clock);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic alignTo(input int r);
    while (cyc % 10 != r) stepCycles(1);
  endtask

  task automatic test_reset();
    logic expTick;
    repeat (5) @(posedge clock);
    #1;
    assertCount++;
    if (led !== 4'b0000) begin failCount++; $display("[TB] FAIL reset_led: got %b expected %b", led, 4'b0000); end
    assertCount++;
    if (tick !== 1'b0) begin failCount++; $display("[TB] FAIL reset_tick: got %b expected %b", tick, 1'b0); end
    @(negedge clock);
    reset = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clock);
      #1;
      expTick = (n % 10 == 9);
      assertCount++;
      if (tick !== expTick) begin failCount++; $display("[TB] FAIL tick_edge%0d: got %b expected %b", n, tick, expTick); end
    end
  endtask

  task automatic test_on_off();
    applyStimulus(2, LED_ON, 16'd0);
    assertCount++;
    if (led !== 4'b0000) begin failCount++; $display("[TB] FAIL on_latency: got %b expected %b", led, 4'b0000); end
    stepCycles(1);
    assertCount++;
    if (led !== 4'b0100) begin failCount++; $display("[TB] FAIL on_ch2: got %b expected %b", led, 4'b0100); end
    applyStimulus(2, LED_OFF, 16'd0);
    stepCycles(1);
    assertCount++;
    if (led !== 4'b0000) begin failCount++; $display("[TB] FAIL off_ch2: got %b expected %b", led, 4'b0000); end
    applyStimulus(9, LED_ON, 16'd0);
    stepCycles(2);
    assertCount++;
    if (led !== 4'b0000) begin failCount++; $display("[TB] FAIL bad_ch9: got %b expected %b", led, 4'b0000); end
    applyStimulus(4, LED_ON, 16'd0);
    stepCycles(2);
    assertCount++;
    if (led !== 4'b0000) begin failCount++; $display("[TB] FAIL bad_ch4: got %b expected %b", led, 4'b0000); end
  endtask

  // Write edge K lands one edge after a tick edge, so ticks register at K+9, K+19, ...
  task automatic test_blink();
    alignTo(0);
    applyStimulus(0, LED_BLINK, 16'd3);
    stepCycles(29);
    assertCount++;
    if (led[0] !== 1'b0) begin failCount++; $display("[TB] FAIL blink3_k29: got %b expected %b", led[0], 1'b0); end
    stepCycles(1);
    assertCount++;
    if (led[0] !== 1'b1) begin failCount++; $display("[TB] FAIL blink3_k30: got %b expected %b", led[0], 1'b1); end
    stepCycles(29);
    assertCount++;
    if (led[0] !== 1'b1) begin failCount++; $display("[TB] FAIL blink3_k59: got %b expected %b", led[0], 1'b1); end
    stepCycles(1);
    assertCount++;
    if (led[0] !== 1'b0) begin failCount++; $display("[TB] FAIL blink3_k60: got %b expected %b", led[0], 1'b0); end
    stepCycles(30);
    assertCount++;
    if (led[0] !== 1'b1) begin failCount++; $display("[TB] FAIL blink3_k90: got %b expected %b", led[0], 1'b1); end

    alignTo(0);
    applyStimulus(0, LED_BLINK, 16'd0);
    stepCycles(9);
    assertCount++;
    if (led[0] !== 1'b0) begin failCount++; $display("[TB] FAIL blink0_k9: got %b expected %b", led[0], 1'b0); end
    stepCycles(1);
    assertCount++;
    if (led[0] !== 1'b1) begin failCount++; $display("[TB] FAIL blink0_k10: got %b expected %b", led[0], 1'b1); end
    stepCycles(9);
    assertCount++;
    if (led[0] !== 1'b1) begin failCount++; $display("[TB] FAIL blink0_k19: got %b expected %b", led[0], 1'b1); end
    stepCycles(1);
    assertCount++;
    if (led[0] !== 1'b0) begin failCount++; $display("[TB] FAIL blink0_k20: got %b expected %b", led[0], 1'b0); end
  endtask

  task automatic test_back_to_back();
    alignTo(0);
    applyStimulus(0, LED_BLINK, 16'd3);
    applyStimulus(3, LED_ON, 16'd0);
    applyStimulus(2, LED_ON, 16'd0);
    applyStimulus(2, LED_OFF, 16'd0);
    assertCount++;
    if (led[3:2] !== 2'b11) begin failCount++; $display("[TB] FAIL b2b_k3: got %b expected %b", led[3:2], 2'b11); end
    stepCycles(1);
    assertCount++;
    if (led[3:2] !== 2'b10) begin failCount++; $display("[TB] FAIL b2b_k4: got %b expected %b", led[3:2], 2'b10); end
    stepCycles(25);
    assertCount++;
    if (led[0] !== 1'b0) begin failCount++; $display("[TB] FAIL isolate_k29: got %b expected %b", led[0], 1'b0); end
    stepCycles(1);
    assertCount++;
    if (led[0] !== 1'b1) begin failCount++; $display("[TB] FAIL isolate_k30: got %b expected %b", led[0], 1'b1); end
  endtask

  // With param=2 each duty lasts 20 edges; any 16-edge window sees every PWM value once.
  task automatic test_breathe();
    int expDuty [0:33] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                           15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0, 1};
    int highCnt;
    alignTo(0);
    applyStimulus(1, LED_BREATHE, 16'd2);
    for (int s = 0; s < 34; s++) begin
      highCnt = 0;
      for (int j = 0; j < 16; j++) begin
        stepCycles(1);
        highCnt += int'(led[1]);
      end
      stepCycles(4);
      assertCount++;
      if (highCnt !== expDuty[s]) begin failCount++; $display("[TB] FAIL breathe_step%0d: got %0d high expected %0d", s, highCnt, expDuty[s]); end
    end
  endtask

  task automatic test_collision();
    alignTo(9);
    applyStimulus(0, LED_BLINK, 16'd2);
    stepCycles(11);
    assertCount++;
    if (led[0] !== 1'b0) begin failCount++; $display("[TB] FAIL collide_k11: got %b expected %b", led[0], 1'b0); end
    stepCycles(9);
    assertCount++;
    if (led[0] !== 1'b0) begin failCount++; $display("[TB] FAIL collide_k20: got %b expected %b", led[0], 1'b0); end
    stepCycles(1);
    assertCount++;
    if (led[0] !== 1'b1) begin failCount++; $display("[TB] FAIL collide_k21: got %b expected %b", led[0], 1'b1); end
    applyStimulus(0, LED_BLINK, 16'd2);
    assertCount++;
    if (led[0] !== 1'b1) begin failCount++; $display("[TB] FAIL rewrite_edge: got %b expected %b", led[0], 1'b1); end
    stepCycles(1);
    assertCount++;
    if (led[0] !== 1'b0) begin failCount++; $display("[TB] FAIL rewrite_next: got %b expected %b", led[0], 1'b0); end
  endtask

  task automatic test_reset_mid();
    assertCount++;
    if (led[3] !== 1'b1) begin failCount++; $display("[TB] FAIL premid_ch3: got %b expected %b", led[3], 1'b1); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    assertCount++;
    if (led !== 4'b0000) begin failCount++; $display("[TB] FAIL async_led: got %b expected %b", led, 4'b0000); end
    assertCount++;
    if (tick !== 1'b0) begin failCount++; $display("[TB] FAIL async_tick: got %b expected %b", tick, 1'b0); end
    @(negedge clock);
    reset = 1'b0;
    stepCycles(8);
    assertCount++;
    if ({led, tick} !== 5'b00000) begin failCount++; $display("[TB] FAIL post_rst_k8: got %b expected %b", {led, tick}, 5'b00000); end
    stepCycles(1);
    assertCount++;
    if (tick !== 1'b1) begin failCount++; $display("[TB] FAIL post_rst_tick: got %b expected %b", tick, 1'b1); end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_on_off();
    test_blink();
    test_back_to_back();
    test_breathe();
    test_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
